// File: rtl/clz_pkg.sv
// Shared constants and FSM encoding for the iterative count-leading-zeros unit.
package clz_pkg;

  localparam int unsigned CLZ_WIDTH = 32;
  localparam int unsigned CLZ_CHUNK = 4;
  localparam int unsigned CLZ_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } clz_state_e;

endpackage

// File: rtl/chunk_lzc.sv
// Combinational CHUNK-bit priority encoder: non-zero flag and leading zeros within the chunk.
module chunk_lzc #(
  parameter int unsigned CHUNK = 4,
  localparam int unsigned LZW  = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] d,
  output logic             nz,
  output logic [LZW-1:0]   lz
);

  // Heap-ordered tree: leaves at CHUNK-1..2*CHUNK-2, root at index 0.
  logic tree [2*CHUNK-1];

  for (genvar i = 0; i < CHUNK; i++) begin : g_leaf
    assign tree[CHUNK-1+i] = d[i];
  end

  for (genvar j = 0; j < CHUNK - 1; j++) begin : g_node
    or_1b u_or (
      .a (tree[2*j+1]),
      .b (tree[2*j+2]),
      .y (tree[j])
    );
  end

  assign nz = tree[0];

  // Scan upward so the highest set bit wins.
  always_comb begin
    lz = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (d[i]) lz = LZW'(CHUNK - 1 - i);
    end
  end

endmodule

// File: rtl/or_1b.sv
// Single two-input OR gate, used as the node of the chunk non-zero reduction tree.
module or_1b (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a | b;

endmodule

// File: rtl/clz32_iter.sv
// Iterative count-leading-zeros: scans MSB-first CHUNK bits per cycle, exits on first set chunk.
// Optional CLZ_CTZ_EN adds a mode input; mode=1 bit-reverses the operand to count trailing zeros.
module clz32_iter
  import clz_pkg::*;
#(
  parameter int unsigned WIDTH = CLZ_WIDTH,
  parameter int unsigned CHUNK = CLZ_CHUNK,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
`ifdef CLZ_CTZ_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned LZW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  clz_state_e       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_val;
  logic             nz;
  logic [LZW-1:0]   lz;

`ifdef CLZ_CTZ_EN
  logic [WIDTH-1:0] a_rev;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign a_rev[i] = a[WIDTH-1-i];
  end
  assign load_val = mode ? a_rev : a;
`else
  assign load_val = a;
`endif

  chunk_lzc #(
    .CHUNK (CHUNK)
  ) u_chunk_lzc (
    .d  (sreg_q[WIDTH-1 -: CHUNK]),
    .nz (nz),
    .lz (lz)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    count_d = count_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SCAN;
          sreg_d  = load_val;
          acc_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (nz) begin
          acc_d   = acc_q + CNT_W'(lz);
          count_d = acc_q + CNT_W'(lz);
          zero_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == CNT_W'(NCH - 1)) begin
          acc_d   = CNT_W'(WIDTH);
          count_d = CNT_W'(WIDTH);
          zero_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          acc_d  = acc_q + CNT_W'(CHUNK);
          sreg_d = sreg_q << CHUNK;
          idx_d  = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == SCAN);
  assign done  = done_q;
  assign count = count_q;
  assign zero  = zero_q;

endmodule
